// File: rtl/core_inst_sequencer.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module  : core_inst_sequencer
// Brief   : Emits the 35-bit core instruction stream for a full single-tile
//           convolution, then the PMEM accumulation pass per output pixel.
// Revision: 1.0 - initial release
// ============================================================================
module core_inst_sequencer #(
    parameter int          ROW           = 8,
    parameter int          COL           = 8,
    parameter int          IN_W          = 6,
    parameter int          K             = 3,
    parameter logic [10:0] X_BASE        = 11'h000,
    parameter logic [10:0] W_BASE        = 11'h400,
    parameter int          GAP_CYCLES    = 10,
    parameter int          DRAIN_TIMEOUT = 256
) (
    input  logic                                        clk,
    input  logic                                        reset,
    input  logic                                        start,
    input  logic                                        ofifo_valid,
    output logic [34:0]                                 inst,
    output logic                                        acc_clr,
    output logic                                        out_valid,
    output logic [$clog2((IN_W-K+1)*(IN_W-K+1))-1:0]    out_idx,
    output logic                                        busy,
    output logic                                        done,
    output logic                                        error
);
    localparam int LEN_NIJ  = IN_W * IN_W;
    localparam int LEN_KIJ  = K * K;
    localparam int OUT_W    = IN_W - K + 1;
    localparam int LEN_ONIJ = OUT_W * OUT_W;
    localparam int IDX_W    = $clog2(LEN_ONIJ);
    localparam int CW       = 16;

    localparam logic [34:0]    c_IDLE_INST  = 35'h1_800C_0000;
    localparam logic [CW-1:0]  c_ONE        = CW'(1);
    localparam logic [CW-1:0]  c_ROW        = CW'(ROW);
    localparam logic [CW-1:0]  c_COL        = CW'(COL);
    localparam logic [CW-1:0]  c_COL_LAST   = CW'(COL - 1);
    localparam logic [CW-1:0]  c_KL_END     = CW'(ROW + COL);
    localparam logic [CW-1:0]  c_GAP_END    = CW'(GAP_CYCLES);
    localparam logic [CW-1:0]  c_NIJ        = CW'(LEN_NIJ);
    localparam logic [CW-1:0]  c_NIJ_LAST   = CW'(LEN_NIJ - 1);
    localparam logic [CW-1:0]  c_EX_END     = CW'(ROW + COL + LEN_NIJ);
    localparam logic [CW-1:0]  c_KIJ_LAST   = CW'(LEN_KIJ - 1);
    localparam logic [CW-1:0]  c_K_LAST     = CW'(K - 1);
    localparam logic [CW-1:0]  c_OUT_W_LAST = CW'(OUT_W - 1);
    localparam logic [CW-1:0]  c_IN_W       = CW'(IN_W);
    localparam logic [CW-1:0]  c_TMO_LAST   = CW'(DRAIN_TIMEOUT - 1);
    localparam logic [CW-1:0]  c_W_BASE     = CW'(W_BASE);
    localparam logic [CW-1:0]  c_X_BASE     = CW'(X_BASE);
    localparam logic [IDX_W-1:0] c_ONIJ_LAST = IDX_W'(LEN_ONIJ - 1);
    localparam logic [IDX_W-1:0] c_IDX_ONE   = IDX_W'(1);

    // PMEM holds LEN_KIJ partial-sum planes; both it and XMEM are 11-bit addressed
    if ((LEN_KIJ * LEN_NIJ > 2048) || (int'(W_BASE) + LEN_KIJ * COL > 2048)) begin : g_param_check
        $error("core_inst_sequencer: parameters overflow the 11-bit address space");
    end

    typedef enum logic [3:0] {
        S_IDLE     = 4'd0,
        S_WL0      = 4'd1,
        S_KLOAD    = 4'd2,
        S_GAP      = 4'd3,
        S_XL0      = 4'd4,
        S_EXEC     = 4'd5,
        S_DRAIN    = 4'd6,
        S_ACC_CLR  = 4'd7,
        S_ACC_RD   = 4'd8,
        S_ACC_WAIT = 4'd9,
        S_DONE     = 4'd10
    } state_t;

    state_t            r_state;
    state_t            w_next;
    logic [34:0]       r_inst;
    logic [34:0]       w_inst;
    logic [CW-1:0]     r_cnt;
    logic [CW-1:0]     r_kij;
    logic [CW-1:0]     r_dcnt;
    logic [CW-1:0]     r_tmo;
    logic [CW-1:0]     r_ki;
    logic [CW-1:0]     r_kj;
    logic [CW-1:0]     r_ox;
    logic [CW-1:0]     r_oy;
    logic [IDX_W-1:0]  r_onij;
    logic              r_error;
    logic              w_dlive;
    logic              w_pop;
    logic              w_timeout;
    logic              w_start_ok;

    assign w_start_ok = (r_state == S_IDLE) && start;
    assign w_dlive    = (r_state == S_DRAIN) && (r_dcnt < c_NIJ);
    assign w_pop      = w_dlive && ofifo_valid;
    assign w_timeout  = w_dlive && !ofifo_valid && (r_tmo == c_TMO_LAST);

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        w_inst = c_IDLE_INST;
        case (r_state)
            S_IDLE: begin
                if (start) w_next = S_WL0;
            end
            S_WL0: begin
                w_inst[19]   = (r_cnt == c_COL);
                w_inst[17:7] = 11'(c_W_BASE + r_kij * c_COL + ((r_cnt < c_COL) ? r_cnt : c_COL_LAST));
                w_inst[2]    = (r_cnt != '0);
                if (r_cnt == c_COL) w_next = S_KLOAD;
            end
            S_KLOAD: begin
                w_inst[0] = (r_cnt < c_KL_END);
                w_inst[3] = (r_cnt < c_ROW);
                if (r_cnt == c_KL_END) w_next = S_GAP;
            end
            S_GAP: begin
                if (r_cnt == c_GAP_END) w_next = S_XL0;
            end
            S_XL0: begin
                w_inst[19]   = (r_cnt == c_NIJ);
                w_inst[17:7] = 11'(c_X_BASE + ((r_cnt < c_NIJ) ? r_cnt : c_NIJ_LAST));
                w_inst[2]    = (r_cnt != '0);
                if (r_cnt == c_NIJ) w_next = S_EXEC;
            end
            S_EXEC: begin
                w_inst[1] = (r_cnt < c_EX_END);
                w_inst[3] = (r_cnt < c_EX_END);
                if (r_cnt == c_EX_END) w_next = S_DRAIN;
            end
            S_DRAIN: begin
                if (w_pop) begin
                    w_inst[34]    = 1'b1;
                    w_inst[32]    = 1'b0;
                    w_inst[31]    = 1'b0;
                    w_inst[30:20] = 11'(r_kij * c_NIJ + r_dcnt);
                    w_inst[6]     = 1'b1;
                end
                if (r_dcnt == c_NIJ) begin
                    w_next = (r_kij == c_KIJ_LAST) ? S_ACC_CLR : S_WL0;
                end else if (w_timeout) begin
                    w_next = S_IDLE;
                end
            end
            S_ACC_CLR: begin
                w_next = S_ACC_RD;
            end
            S_ACC_RD: begin
                // Plane j holds kernel tap (ki,kj); read the input pixel it touched
                w_inst[33]    = 1'b1;
                w_inst[32]    = 1'b0;
                w_inst[30:20] = 11'(r_cnt * c_NIJ + (r_oy + r_ki) * c_IN_W + r_ox + r_kj);
                if (r_cnt == c_KIJ_LAST) w_next = S_ACC_WAIT;
            end
            S_ACC_WAIT: begin
                if (r_cnt == c_ONE) w_next = (r_onij == c_ONIJ_LAST) ? S_DONE : S_ACC_CLR;
            end
            S_DONE: begin
                w_next = S_IDLE;
            end
            default: begin
                w_next = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_inst  <= c_IDLE_INST;
            r_cnt   <= '0;
            r_kij   <= '0;
            r_dcnt  <= '0;
            r_tmo   <= '0;
            r_ki    <= '0;
            r_kj    <= '0;
            r_ox    <= '0;
            r_oy    <= '0;
            r_onij  <= '0;
            r_error <= 1'b0;
        end else begin
            r_inst <= w_inst;
            r_cnt  <= (w_next != r_state) ? '0 : r_cnt + c_ONE;

            if (r_state == S_IDLE) begin
                r_kij <= '0;
            end else if ((r_state == S_DRAIN) && (w_next == S_WL0)) begin
                r_kij <= r_kij + c_ONE;
            end

            if (r_state != S_DRAIN) begin
                r_dcnt <= '0;
            end else if (w_pop) begin
                r_dcnt <= r_dcnt + c_ONE;
            end

            // Counts only consecutive empty cycles; any pop restarts the window
            if ((r_state != S_DRAIN) || w_pop) begin
                r_tmo <= '0;
            end else if (w_dlive) begin
                r_tmo <= r_tmo + c_ONE;
            end

            if (r_state != S_ACC_RD) begin
                r_ki <= '0;
                r_kj <= '0;
            end else if (r_kj == c_K_LAST) begin
                r_kj <= '0;
                r_ki <= r_ki + c_ONE;
            end else begin
                r_kj <= r_kj + c_ONE;
            end

            if (r_state == S_IDLE) begin
                r_onij <= '0;
                r_ox   <= '0;
                r_oy   <= '0;
            end else if ((r_state == S_ACC_WAIT) && (w_next == S_ACC_CLR)) begin
                r_onij <= r_onij + c_IDX_ONE;
                if (r_ox == c_OUT_W_LAST) begin
                    r_ox <= '0;
                    r_oy <= r_oy + c_ONE;
                end else begin
                    r_ox <= r_ox + c_ONE;
                end
            end

            if (w_start_ok) begin
                r_error <= 1'b0;
            end else if (w_timeout) begin
                r_error <= 1'b1;
            end
        end
    end

    assign inst      = r_inst;
    assign acc_clr   = (r_state == S_ACC_CLR);
    assign out_valid = (r_state == S_ACC_WAIT) && (r_cnt == c_ONE);
    assign out_idx   = r_onij;
    assign busy      = (r_state != S_IDLE);
    assign done      = (r_state == S_DONE);
    assign error     = r_error;

endmodule
`default_nettype wire
